// File: rtl/q2a03_bus_pkg.sv
// rtl/q2a03_bus_pkg.sv - Shared types and constants for the Q2A03 bus target.
package q2a03_bus_pkg;

  typedef enum logic [1:0] {REG_RAM, REG_TIMER, REG_EXT, REG_OPEN} region_e;
  typedef enum logic [1:0] {EXT_IDLE, EXT_WAIT, EXT_DONE} ext_state_e;

  localparam logic [1:0] TMR_RELOAD_LO = 2'd0;
  localparam logic [1:0] TMR_RELOAD_HI = 2'd1;
  localparam logic [1:0] TMR_CTRL      = 2'd2;
  localparam logic [1:0] TMR_STATUS    = 2'd3;

  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int STAT_PENDING = 0;
  localparam int STAT_TIMEOUT = 1;

  // RAM mirror always covers $0000-$1FFF; the timer window is 4 bytes from its base.
  function automatic region_e decode_region(input logic [15:0] addr,
                                            input logic [15:0] timer_base,
                                            input logic [15:0] ext_base);
    logic [15:0] off;
    off = addr - timer_base;
    if (addr < 16'h2000)        return REG_RAM;
    else if (addr >= ext_base)  return REG_EXT;
    else if (off < 16'd4)       return REG_TIMER;
    else                        return REG_OPEN;
  endfunction

endpackage

// File: rtl/q2a03_bus_if.sv
// rtl/q2a03_bus_if.sv - CPU-side bus and external-memory handshake interfaces.
interface q2a03_bus_if;
  logic        G_phy2;
  logic [15:0] G_addr;
  logic        G_rdwr;
  logic [7:0]  G_wr_data;
  logic [7:0]  G_rd_data;
  logic        G_ready;
  logic        G_irq;

  modport master (output G_phy2, G_addr, G_rdwr, G_wr_data,
                  input  G_rd_data, G_ready, G_irq);
  modport slave  (input  G_phy2, G_addr, G_rdwr, G_wr_data,
                  output G_rd_data, G_ready, G_irq);
endinterface

interface q2a03_ext_if;
  logic [14:0] ext_addr;
  logic        ext_we;
  logic [7:0]  ext_wr_data;
  logic        ext_req;
  logic        ext_ack;
  logic [7:0]  ext_rd_data;

  modport master (output ext_addr, ext_we, ext_wr_data, ext_req,
                  input  ext_ack, ext_rd_data);
  modport slave  (input  ext_addr, ext_we, ext_wr_data, ext_req,
                  output ext_ack, ext_rd_data);
endinterface

// File: rtl/q2a03_bus_timer.sv
// rtl/q2a03_bus_timer.sv - Interval timer: reload/ctrl/status registers, down-counter and irq.
module q2a03_bus_timer
  import q2a03_bus_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic       i_wr,
  input  logic [1:0] i_reg,
  input  logic [7:0] i_wr_data,
  input  logic       i_timeout_set,
  output logic [7:0] o_rd_data,
  output logic       o_irq_n
);
  logic [15:0] r_reload;
  logic [15:0] r_count;
  logic [1:0]  r_ctrl;
  logic        r_pending;
  logic        r_timeout;

  logic w_ctrl_wr;
  logic w_stat_wr;
  logic w_en_rise;
  logic w_underflow;

  assign w_ctrl_wr   = i_wr && (i_reg == TMR_CTRL);
  assign w_stat_wr   = i_wr && (i_reg == TMR_STATUS);
  assign w_en_rise   = w_ctrl_wr && i_wr_data[CTRL_ENABLE] && !r_ctrl[CTRL_ENABLE];
  assign w_underflow = i_tick && r_ctrl[CTRL_ENABLE] && (r_count == 16'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_reload  <= 16'd0;
      r_count   <= 16'd0;
      r_ctrl    <= 2'b00;
      r_pending <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (i_wr && (i_reg == TMR_RELOAD_LO)) r_reload[7:0]  <= i_wr_data;
      if (i_wr && (i_reg == TMR_RELOAD_HI)) r_reload[15:8] <= i_wr_data;
      if (w_ctrl_wr) r_ctrl <= i_wr_data[1:0];

      if (w_en_rise)
        r_count <= r_reload;
      else if (i_tick && r_ctrl[CTRL_ENABLE])
        r_count <= (r_count == 16'd0) ? r_reload : r_count - 16'd1;

      // A set in the same clock as a write-1-clear must survive.
      if (w_underflow)
        r_pending <= 1'b1;
      else if (w_stat_wr && i_wr_data[STAT_PENDING])
        r_pending <= 1'b0;

      if (i_timeout_set)
        r_timeout <= 1'b1;
      else if (w_stat_wr && i_wr_data[STAT_TIMEOUT])
        r_timeout <= 1'b0;
    end
  end

  always_comb begin
    o_rd_data = 8'h00;
    unique case (i_reg)
      TMR_RELOAD_LO: o_rd_data = r_reload[7:0];
      TMR_RELOAD_HI: o_rd_data = r_reload[15:8];
      TMR_CTRL:      o_rd_data = {6'b0, r_ctrl};
      TMR_STATUS:    o_rd_data = {6'b0, r_timeout, r_pending};
      default:       o_rd_data = 8'h00;
    endcase
  end

  assign o_irq_n = ~(r_pending & r_ctrl[CTRL_IRQ_EN]);

endmodule

// File: rtl/q2a03_bus_target.sv
// rtl/q2a03_bus_target.sv - Q2A03 CPU bus target: mirrored RAM, timer block, stretched external region.
module q2a03_bus_target
  import q2a03_bus_pkg::*;
#(
  parameter int          RAM_AW      = 11,
  parameter logic [15:0] TIMER_BASE  = 16'h4020,
  parameter logic [15:0] EXT_BASE    = 16'h8000,
  parameter int          EXT_TIMEOUT = 255
) (
  input  logic        G_clock,
  input  logic        G_reset,
  q2a03_bus_if.slave  bus,
  q2a03_ext_if.master ext
);
  localparam int            CW       = $clog2(EXT_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(EXT_TIMEOUT - 1);

  logic [7:0]    r_ram [0:(1 << RAM_AW) - 1];
  logic          r_phy2_q;
  logic          r_rise_d;
  logic [15:0]   r_addr;
  logic          r_rdwr;
  logic          r_skip;
  logic [7:0]    r_rd_data;
  logic          r_ready;
  logic [14:0]   r_ext_addr;
  logic          r_ext_we;
  logic [7:0]    r_ext_wr_data;
  logic          r_ext_req;
  logic [CW-1:0] r_wait_cnt;
  logic [15:0]   r_done_addr;
  logic          r_done_valid;
  ext_state_e    r_state;
  ext_state_e    w_state_next;

  logic          w_rise;
  logic          w_fall;
  logic          w_rise_accept;
  logic          w_match;
  logic          w_start;
  logic          w_ack_take;
  logic          w_timeout_hit;
  logic          w_wr_fall;
  region_e       w_region;
  logic [7:0]    w_tmr_rd_data;
  logic          w_irq_n;

  assign w_rise        = bus.G_phy2 & ~r_phy2_q;
  assign w_fall        = ~bus.G_phy2 & r_phy2_q;
  assign w_rise_accept = w_rise && (r_state != EXT_WAIT);
  assign w_region      = decode_region(r_addr, TIMER_BASE, EXT_BASE);
  assign w_wr_fall     = w_fall && !r_rdwr;
  // The repeat of a just-finished EXT cycle is answered from the held data, not re-issued.
  assign w_match       = ((r_state == EXT_DONE) && (bus.G_addr == r_addr)) ||
                         (r_done_valid && (bus.G_addr == r_done_addr));
  assign w_start       = w_fall && (w_region == REG_EXT) && !r_skip && (r_state == EXT_IDLE);

  always_ff @(posedge G_clock or negedge G_reset) begin
    if (!G_reset) r_state <= EXT_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_ack_take    = 1'b0;
    w_timeout_hit = 1'b0;
    unique case (r_state)
      EXT_IDLE: if (w_start) w_state_next = EXT_WAIT;
      EXT_WAIT: begin
        if (ext.ext_ack) begin
          w_ack_take   = 1'b1;
          w_state_next = EXT_DONE;
        end else if (r_wait_cnt == CNT_LAST) begin
          w_timeout_hit = 1'b1;
          w_state_next  = EXT_DONE;
        end
      end
      EXT_DONE: w_state_next = EXT_IDLE;
      default:  w_state_next = EXT_IDLE;
    endcase
  end

  always_ff @(posedge G_clock) begin
    if (w_wr_fall && (w_region == REG_RAM))
      r_ram[r_addr[RAM_AW-1:0]] <= bus.G_wr_data;
  end

  always_ff @(posedge G_clock or negedge G_reset) begin
    if (!G_reset) begin
      r_phy2_q      <= 1'b1;
      r_rise_d      <= 1'b0;
      r_addr        <= 16'd0;
      r_rdwr        <= 1'b1;
      r_skip        <= 1'b0;
      r_rd_data     <= 8'h00;
      r_ready       <= 1'b1;
      r_ext_addr    <= 15'd0;
      r_ext_we      <= 1'b0;
      r_ext_wr_data <= 8'h00;
      r_ext_req     <= 1'b0;
      r_wait_cnt    <= '0;
      r_done_addr   <= 16'd0;
      r_done_valid  <= 1'b0;
    end else begin
      r_phy2_q <= bus.G_phy2;
      r_rise_d <= w_rise_accept;

      if (r_state == EXT_DONE) begin
        r_ready      <= 1'b1;
        r_done_addr  <= r_addr;
        r_done_valid <= 1'b1;
      end

      if (w_rise_accept) begin
        r_addr       <= bus.G_addr;
        r_rdwr       <= bus.G_rdwr;
        r_skip       <= w_match;
        r_done_valid <= 1'b0;
      end

      if (r_rise_d && r_rdwr) begin
        if (w_region == REG_RAM)        r_rd_data <= r_ram[r_addr[RAM_AW-1:0]];
        else if (w_region == REG_TIMER) r_rd_data <= w_tmr_rd_data;
      end

      // Writes leave their data on the bus; open-bus reads return it later.
      if (w_wr_fall && ((w_region != REG_EXT) || w_start))
        r_rd_data <= bus.G_wr_data;

      if (w_start) begin
        r_ext_addr    <= r_addr[14:0];
        r_ext_we      <= ~r_rdwr;
        r_ext_wr_data <= bus.G_wr_data;
        r_ext_req     <= 1'b1;
        r_ready       <= 1'b0;
        r_wait_cnt    <= '0;
      end

      if (r_state == EXT_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;

      if (w_ack_take) begin
        r_ext_req <= 1'b0;
        if (r_rdwr) r_rd_data <= ext.ext_rd_data;
      end

      if (w_timeout_hit) begin
        r_ext_req <= 1'b0;
        if (r_rdwr) r_rd_data <= 8'hFF;
      end
    end
  end

  q2a03_bus_timer u_timer (
    .i_clk         (G_clock),
    .i_rst_n       (G_reset),
    .i_tick        (w_rise),
    .i_wr          (w_wr_fall && (w_region == REG_TIMER)),
    .i_reg         (r_addr[1:0]),
    .i_wr_data     (bus.G_wr_data),
    .i_timeout_set (w_timeout_hit),
    .o_rd_data     (w_tmr_rd_data),
    .o_irq_n       (w_irq_n)
  );

  assign bus.G_rd_data   = r_rd_data;
  assign bus.G_ready     = r_ready;
  assign bus.G_irq       = w_irq_n;
  assign ext.ext_addr    = r_ext_addr;
  assign ext.ext_we      = r_ext_we;
  assign ext.ext_wr_data = r_ext_wr_data;
  assign ext.ext_req     = r_ext_req;

endmodule

// File: tb/tb_q2a03_bus_target.sv
// tb/tb_q2a03_bus_target.sv - Directed table-driven bench for q2a03_bus_target.
module tb_q2a03_bus_target;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  q2a03_bus_if bus();
  q2a03_ext_if ext();

  q2a03_bus_target #(
    .RAM_AW      (11),
    .TIMER_BASE  (16'h4020),
    .EXT_BASE    (16'h8000),
    .EXT_TIMEOUT (255)
  ) dut (
    .G_clock (clk),
    .G_reset (rst_n),
    .bus     (bus),
    .ext     (ext)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // External memory responder and observer.
  int          ack_delay = -1;
  logic [7:0]  ack_data  = 8'h00;
  int          req_cnt = 0, req_len = 0, req_starts = 0, rdy_while_req = 0, stage = 0;
  logic [14:0] seen_addr = '0;
  logic        seen_we = 1'b0;
  logic [7:0]  seen_wd = '0;
  logic [7:0]  rd_at_ack = '0;
  logic        rdy_at_ack = 1'b0, rdy_after_ack = 1'b0;

  initial begin
    ext.ext_ack     = 1'b0;
    ext.ext_rd_data = 8'h00;
    forever begin
      @(negedge clk);
      ext.ext_ack = 1'b0;
      if (stage == 1) begin
        rd_at_ack  = bus.G_rd_data;
        rdy_at_ack = bus.G_ready;
        stage      = 2;
      end else if (stage == 2) begin
        rdy_after_ack = bus.G_ready;
        stage         = 0;
      end
      if (ext.ext_req) begin
        if (req_cnt == 0) begin
          req_starts++;
          seen_addr = ext.ext_addr;
          seen_we   = ext.ext_we;
          seen_wd   = ext.ext_wr_data;
        end
        req_cnt++;
        if (bus.G_ready) rdy_while_req++;
        if (ack_delay > 0 && req_cnt == ack_delay) begin
          ext.ext_ack     = 1'b1;
          ext.ext_rd_data = ack_data;
          stage           = 1;
        end
      end else if (req_cnt != 0) begin
        req_len = req_cnt;
        req_cnt = 0;
      end
    end
  end

  // One 12-clock CPU cycle: 6 clocks with phy2 high, 6 low.
  task automatic bus_cycle(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                           output logic [7:0] rd_rise, output logic [7:0] rd_early,
                           output logic [7:0] rd_end, output logic rdy_end, output logic irq_end);
    @(negedge clk);
    bus.G_phy2 = 1'b1; bus.G_addr = a; bus.G_rdwr = rw; bus.G_wr_data = wd;
    @(negedge clk);
    rd_rise = bus.G_rd_data;
    @(negedge clk);
    rd_early = bus.G_rd_data;
    repeat (4) @(negedge clk);
    bus.G_phy2 = 1'b0;
    repeat (5) @(negedge clk);
    rd_end  = bus.G_rd_data;
    rdy_end = bus.G_ready;
    irq_end = bus.G_irq;
  endtask

  // Repeats the cycle while the target stretches it, bounded to 40 cycles.
  task automatic ext_access(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                            output logic [7:0] rd_end, output logic rdy_end);
    logic [7:0] r0, r1;
    logic       irq;
    int         n;
    n = 0;
    do begin
      bus_cycle(a, rw, wd, r0, r1, rd_end, rdy_end, irq);
      n++;
    end while (!rdy_end && n < 40);
  endtask

  typedef struct packed {
    logic [15:0] addr;
    logic        rdwr;
    logic [7:0]  wdata;
    logic [7:0]  exp;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  logic [7:0] rr, re, rn, prev_bus;
  logic       rdy, irq;
  int         starts0;

  initial begin
    vecs[0]  = '{16'h0005, 1'b0, 8'h3C, 8'h3C};
    vecs[1]  = '{16'h0805, 1'b1, 8'h00, 8'h3C};
    vecs[2]  = '{16'h1FFF, 1'b0, 8'h5A, 8'h5A};
    vecs[3]  = '{16'h07FF, 1'b1, 8'h00, 8'h5A};
    vecs[4]  = '{16'h0000, 1'b0, 8'h11, 8'h11};
    vecs[5]  = '{16'h1800, 1'b1, 8'h00, 8'h11};
    vecs[6]  = '{16'h0005, 1'b1, 8'h00, 8'h3C};
    vecs[7]  = '{16'h4020, 1'b0, 8'h34, 8'h34};
    vecs[8]  = '{16'h4021, 1'b0, 8'h12, 8'h12};
    vecs[9]  = '{16'h4020, 1'b1, 8'h00, 8'h34};
    vecs[10] = '{16'h4021, 1'b1, 8'h00, 8'h12};
    vecs[11] = '{16'h4022, 1'b1, 8'h00, 8'h00};
    vecs[12] = '{16'h4023, 1'b1, 8'h00, 8'h00};
    vecs[13] = '{16'h0010, 1'b0, 8'h77, 8'h77};
    vecs[14] = '{16'h5000, 1'b1, 8'h00, 8'h77};
    vecs[15] = '{16'h4024, 1'b1, 8'h00, 8'h77};
    vecs[16] = '{16'h6000, 1'b0, 8'h99, 8'h99};
    vecs[17] = '{16'h5FFF, 1'b1, 8'h00, 8'h99};
    vecs[18] = '{16'h0010, 1'b1, 8'h00, 8'h77};
    vecs[19] = '{16'h7FFF, 1'b1, 8'h00, 8'h77};
    vecs[20] = '{16'h401F, 1'b1, 8'h00, 8'h77};

    bus.G_phy2 = 1'b0; bus.G_addr = 16'h0000; bus.G_rdwr = 1'b1; bus.G_wr_data = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst rd_data", 32'(bus.G_rd_data), 32'h00);
    check("rst ready", 32'(bus.G_ready), 32'h1);
    check("rst irq", 32'(bus.G_irq), 32'h1);
    check("rst ext_req", 32'(ext.ext_req), 32'h0);
    check("rst ext_we", 32'(ext.ext_we), 32'h0);
    check("rst ext_addr", 32'(ext.ext_addr), 32'h0);
    check("rst ext_wr_data", 32'(ext.ext_wr_data), 32'h0);

    prev_bus = 8'h00;
    for (int i = 0; i < NV; i++) begin
      bus_cycle(vecs[i].addr, vecs[i].rdwr, vecs[i].wdata, rr, re, rn, rdy, irq);
      if (vecs[i].rdwr) begin
        check($sformatf("v%0d rd_hold", i), 32'(rr), 32'(prev_bus));
        check($sformatf("v%0d rd_data", i), 32'(re), 32'(vecs[i].exp));
      end else begin
        check($sformatf("v%0d wr_bus", i), 32'(rn), 32'(vecs[i].exp));
      end
      check($sformatf("v%0d ready", i), 32'(rdy), 32'h1);
      check($sformatf("v%0d irq", i), 32'(irq), 32'h1);
      prev_bus = vecs[i].exp;
    end

    // Timer: RELOAD=2, enable with irq.
    bus_cycle(16'h4020, 1'b0, 8'h02, rr, re, rn, rdy, irq);
    bus_cycle(16'h4021, 1'b0, 8'h00, rr, re, rn, rdy, irq);
    bus_cycle(16'h4022, 1'b0, 8'h03, rr, re, rn, rdy, irq);
    bus_cycle(16'h0000, 1'b1, 8'h00, rr, re, rn, rdy, irq);
    check("tmr rise1 irq", 32'(irq), 32'h1);
    bus_cycle(16'h0000, 1'b1, 8'h00, rr, re, rn, rdy, irq);
    check("tmr rise2 irq", 32'(irq), 32'h1);
    bus_cycle(16'h0000, 1'b1, 8'h00, rr, re, rn, rdy, irq);
    check("tmr rise3 irq", 32'(irq), 32'h0);
    bus_cycle(16'h4023, 1'b0, 8'h01, rr, re, rn, rdy, irq);
    check("tmr w1c irq", 32'(irq), 32'h1);
    bus_cycle(16'h0000, 1'b1, 8'h00, rr, re, rn, rdy, irq);
    check("tmr again rise2 irq", 32'(irq), 32'h1);
    bus_cycle(16'h0000, 1'b1, 8'h00, rr, re, rn, rdy, irq);
    check("tmr again rise3 irq", 32'(irq), 32'h0);
    bus_cycle(16'h4023, 1'b1, 8'h00, rr, re, rn, rdy, irq);
    check("tmr status pending", 32'(re), 32'h01);
    bus_cycle(16'h4022, 1'b0, 8'h00, rr, re, rn, rdy, irq);
    bus_cycle(16'h4023, 1'b0, 8'h03, rr, re, rn, rdy, irq);
    check("tmr off irq", 32'(irq), 32'h1);
    bus_cycle(16'h4023, 1'b1, 8'h00, rr, re, rn, rdy, irq);
    check("tmr status clear", 32'(re), 32'h00);

    // EXT read, ack 4 clocks after request.
    ack_delay = 4; ack_data = 8'hA5; starts0 = req_starts;
    ext_access(16'hC123, 1'b1, 8'h00, rn, rdy);
    check("ext rd ready_end", 32'(rdy), 32'h1);
    check("ext rd data_end", 32'(rn), 32'hA5);
    check("ext rd addr", 32'(seen_addr), 32'h4123);
    check("ext rd we", 32'(seen_we), 32'h0);
    check("ext rd req_len", 32'(req_len), 32'd4);
    check("ext rd starts", 32'(req_starts - starts0), 32'd1);
    check("ext rd stretch", 32'(rdy_while_req), 32'd0);
    check("ext rd data_at_ack", 32'(rd_at_ack), 32'hA5);
    check("ext rd ready_at_ack", 32'(rdy_at_ack), 32'h0);
    check("ext rd ready_after_ack", 32'(rdy_after_ack), 32'h1);

    // EXT write that never gets acknowledged.
    ack_delay = -1; starts0 = req_starts;
    ext_access(16'h9000, 1'b0, 8'h42, rn, rdy);
    check("ext to ready_end", 32'(rdy), 32'h1);
    check("ext to req_len", 32'(req_len), 32'd255);
    check("ext to we", 32'(seen_we), 32'h1);
    check("ext to wr_data", 32'(seen_wd), 32'h42);
    check("ext to addr", 32'(seen_addr), 32'h1000);
    bus_cycle(16'h9000, 1'b0, 8'h42, rr, re, rn, rdy, irq);
    check("ext to repeat ready", 32'(rdy), 32'h1);
    check("ext to repeat no restart", 32'(req_starts - starts0), 32'd1);
    bus_cycle(16'h4023, 1'b1, 8'h00, rr, re, rn, rdy, irq);
    check("ext to status", 32'(re), 32'h02);

    starts0 = req_starts;
    ext_access(16'h8001, 1'b1, 8'h00, rn, rdy);
    check("ext to rd ready_end", 32'(rdy), 32'h1);
    check("ext to rd data", 32'(rn), 32'hFF);
    check("ext to rd starts", 32'(req_starts - starts0), 32'd1);
    bus_cycle(16'h4023, 1'b0, 8'h02, rr, re, rn, rdy, irq);
    bus_cycle(16'h4023, 1'b1, 8'h00, rr, re, rn, rdy, irq);
    check("ext status w1c", 32'(re), 32'h00);

    // Reset in the middle of an EXT wait with the timer irq pending.
    bus_cycle(16'h4020, 1'b0, 8'h00, rr, re, rn, rdy, irq);
    bus_cycle(16'h4021, 1'b0, 8'h00, rr, re, rn, rdy, irq);
    bus_cycle(16'h4022, 1'b0, 8'h03, rr, re, rn, rdy, irq);
    bus_cycle(16'h8800, 1'b1, 8'h00, rr, re, rn, rdy, irq);
    check("mid pre ready", 32'(rdy), 32'h0);
    check("mid pre irq", 32'(irq), 32'h0);
    check("mid pre req", 32'(ext.ext_req), 32'h1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid rst req", 32'(ext.ext_req), 32'h0);
    check("mid rst ready", 32'(bus.G_ready), 32'h1);
    check("mid rst irq", 32'(bus.G_irq), 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus_cycle(16'h0123, 1'b0, 8'hC7, rr, re, rn, rdy, irq);
    bus_cycle(16'h0123, 1'b1, 8'h00, rr, re, rn, rdy, irq);
    check("post rst ram rd", 32'(re), 32'hC7);
    check("post rst ready", 32'(rdy), 32'h1);
    bus_cycle(16'h4022, 1'b1, 8'h00, rr, re, rn, rdy, irq);
    check("post rst ctrl", 32'(re), 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
